bit_serial_alu_ctrl: RTL

- Sequencer that runs one 1-bit ALU slice over a WIDTH-bit operand pair, one bit per clock, LSB first.
- Latches operands and the function code on a start/done handshake.
- Drives the slice's a/b/invb/cin/ctl inputs and registers its carry between bits.
- Assembles the result word and the zero, overflow and carry-out flags.
- Sits between the instruction-decode stage and the register-file writeback as the execute unit of the serial datapath.

---
 rtl/alu_defs.sv | 21 ++
 rtl/One_bit_alu_slice.sv | 33 +++
 rtl/bit_serial_alu_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/alu_defs.sv
// Shared funct codes and sequencer state encoding for the bit-serial execute unit.
package alu_defs;

    localparam logic [5:0] FN_ADD = 6'd32;
    localparam logic [5:0] FN_SUB = 6'd34;
    localparam logic [5:0] FN_AND = 6'd36;
    localparam logic [5:0] FN_OR  = 6'd37;
    localparam logic [5:0] FN_SLT = 6'd42;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    function automatic logic fn_legal(input logic [5:0] f);
        return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) ||
               (f == FN_OR)  || (f == FN_SLT);
    endfunction

endpackage

// File: rtl/One_bit_alu_slice.sv
// One-bit ALU slice: and/or/add with optional B inversion; unknown codes fall back to add.
module One_bit_alu_slice
    import alu_defs::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       invb,
    input  logic       cin,
    input  logic [5:0] ctl,
    output logic       res,
    output logic       cout,
    output logic       set
);

    logic bb;
    logic sum;

    assign bb   = b ^ invb;
    assign sum  = a ^ bb ^ cin;
    assign cout = (a & bb) | (a & cin) | (bb & cin);
    // Raw adder sum; at the MSB this is the sign used for slt.
    assign set  = sum;

    always_comb begin
        res = sum;
        case (ctl)
            FN_AND:  res = a & bb;
            FN_OR:   res = a | bb;
            default: res = sum;
        endcase
    end

endmodule

// File: rtl/bit_serial_alu_ctrl.sv
// Bit-serial execute unit: walks one ALU slice across WIDTH bits, LSB first,
// then assembles the result word and zero/ovf/cout/illegal flags.
module bit_serial_alu_ctrl
    import alu_defs::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [5:0]       ctl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             ovf,
    output logic             cout,
    output logic             illegal
);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sr_q, a_sr_d, b_sr_q, b_sr_d, res_sr_q, res_sr_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [5:0]         ctl_q, ctl_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               invb_q, invb_d, carry_q, carry_d;
    logic               msb_set_q, msb_set_d, cin_msb_q, cin_msb_d;
    logic               busy_q, busy_d, done_q, done_d;
    logic               zero_q, zero_d, ovf_q, ovf_d, cout_q, cout_d, illegal_q, illegal_d;
    logic               s_res, s_cout, s_set;

    One_bit_alu_slice u_slice (
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .invb (invb_q),
        .cin  (carry_q),
        .ctl  (ctl_q),
        .res  (s_res),
        .cout (s_cout),
        .set  (s_set)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            a_sr_q    <= '0;
            b_sr_q    <= '0;
            res_sr_q  <= '0;
            result_q  <= '0;
            ctl_q     <= '0;
            cnt_q     <= '0;
            invb_q    <= 1'b0;
            carry_q   <= 1'b0;
            msb_set_q <= 1'b0;
            cin_msb_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            zero_q    <= 1'b0;
            ovf_q     <= 1'b0;
            cout_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_sr_q    <= a_sr_d;
            b_sr_q    <= b_sr_d;
            res_sr_q  <= res_sr_d;
            result_q  <= result_d;
            ctl_q     <= ctl_d;
            cnt_q     <= cnt_d;
            invb_q    <= invb_d;
            carry_q   <= carry_d;
            msb_set_q <= msb_set_d;
            cin_msb_q <= cin_msb_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            zero_q    <= zero_d;
            ovf_q     <= ovf_d;
            cout_q    <= cout_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        logic ovf_raw;
        logic sub_like;
        state_d   = state_q;
        a_sr_d    = a_sr_q;
        b_sr_d    = b_sr_q;
        res_sr_d  = res_sr_q;
        result_d  = result_q;
        ctl_d     = ctl_q;
        cnt_d     = cnt_q;
        invb_d    = invb_q;
        carry_d   = carry_q;
        msb_set_d = msb_set_q;
        cin_msb_d = cin_msb_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        zero_d    = zero_q;
        ovf_d     = ovf_q;
        cout_d    = cout_q;
        illegal_d = illegal_q;
        ovf_raw   = cin_msb_q ^ carry_q;
        sub_like  = (ctl == FN_SUB) || (ctl == FN_SLT);

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sr_d    = a;
                    b_sr_d    = b;
                    ctl_d     = ctl;
                    invb_d    = sub_like;
                    carry_d   = sub_like;
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    illegal_d = !fn_legal(ctl);
                    state_d   = RUN;
                end
            end
            RUN: begin
                res_sr_d = {s_res, res_sr_q[WIDTH-1:1]};
                carry_d  = s_cout;
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    // Carry into the MSB is the pre-update carry FF; needed for signed overflow.
                    msb_set_d = s_set;
                    cin_msb_d = carry_q;
                    state_d   = FINISH;
                end
            end
            FINISH: begin
                if (ctl_q == FN_SLT) result_d = WIDTH'(msb_set_q ^ ovf_raw);
                else                 result_d = res_sr_q;
                ovf_d   = ((ctl_q == FN_ADD) || (ctl_q == FN_SUB)) ? ovf_raw : 1'b0;
                cout_d  = ((ctl_q == FN_AND) || (ctl_q == FN_OR)) ? 1'b0 : carry_q;
                zero_d  = (result_d == '0);
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign result  = result_q;
    assign zero    = zero_q;
    assign ovf     = ovf_q;
    assign cout    = cout_q;
    assign illegal = illegal_q;

endmodule
